// File: rtl/fifo_tx_sched_pkg.sv
// Shared types and constants for the FIFO-to-transmitter drain scheduler.
// Holds the state encoding and a counter-width helper used by the top level.
package fifo_tx_sched_pkg;

   localparam int unsigned DefDataW = 8;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLoad   = 3'd1,
      StStart  = 3'd2,
      StWaitTx = 3'd3,
      StGap    = 3'd4
   } state_e;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val <= 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/fifo_tx_sched_if.sv
// FIFO read port and transmitter handshake bundled for the drain scheduler.
// master = scheduler side, slave = FIFO/transmitter side.
interface fifo_tx_sched_if
   import fifo_tx_sched_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW
);

   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_rdata;
   logic              fifo_pop;
   logic              tx_busy;
   logic              tx_done;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;

   modport master (
      input  fifo_empty,
      input  fifo_rdata,
      input  tx_busy,
      input  tx_done,
      output fifo_pop,
      output tx_start,
      output tx_data
   );

   modport slave (
      output fifo_empty,
      output fifo_rdata,
      output tx_busy,
      output tx_done,
      input  fifo_pop,
      input  tx_start,
      input  tx_data
   );

endinterface

// File: rtl/fifo_tx_sched_down_counter.sv
// Loadable down-counter with a registered-state zero flag.
// Decrement saturates at zero; load has priority over decrement.
module sched_down_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/fifo_tx_sched.sv
// Drain scheduler: pops one byte from the FIFO, launches the transmitter, waits for
// completion with a watchdog, and optionally idles for a fixed gap between bytes.
module fifo_tx_sched
   import fifo_tx_sched_pkg::*;
#(
   parameter int unsigned DATA_W         = DefDataW,
   parameter int unsigned GAP_CYCLES     = 0,
   parameter int unsigned TIMEOUT_CYCLES = 4095,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             err_clr,
   fifo_tx_sched_if.master  bus,
   output logic             busy,
   output logic [CNT_W-1:0] sent_cnt,
   output logic             err
);

   localparam int unsigned GapW = cnt_width(GAP_CYCLES);
   localparam int unsigned ToW  = cnt_width(TIMEOUT_CYCLES);

   // Counters are loaded with N-1 so the zero flag fires on the N-th cycle.
   localparam logic [GapW-1:0] GapLoad = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [ToW-1:0]  ToLoad  = ToW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_e state_q, state_d;

   logic              pop_q;
   logic              start_q;
   logic              busy_q;
   logic [DATA_W-1:0] tx_data_q;
   logic [CNT_W-1:0]  sent_q;
   logic              err_q;

   logic gap_load, gap_dec, gap_zero;
   logic to_load, to_dec, to_zero;
   logic done_hit, timeout_hit;

   sched_down_counter #(
      .W (GapW)
   ) u_gap_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (gap_load),
      .load_val (GapLoad),
      .dec      (gap_dec),
      .zero     (gap_zero)
   );

   sched_down_counter #(
      .W (ToW)
   ) u_to_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (to_load),
      .load_val (ToLoad),
      .dec      (to_dec),
      .zero     (to_zero)
   );

   always_comb begin
      state_d     = state_q;
      gap_load    = 1'b0;
      gap_dec     = 1'b0;
      to_load     = 1'b0;
      to_dec      = 1'b0;
      done_hit    = 1'b0;
      timeout_hit = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (enable && !bus.fifo_empty && !bus.tx_busy) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            state_d = StStart;
         end
         StStart: begin
            to_load = 1'b1;
            state_d = StWaitTx;
         end
         StWaitTx: begin
            if (bus.tx_done) begin
               done_hit = 1'b1;
               if (GAP_CYCLES > 0) begin
                  gap_load = 1'b1;
                  state_d  = StGap;
               end else begin
                  state_d = StIdle;
               end
            end else if (to_zero) begin
               // Watchdog expired: the byte is abandoned and not counted.
               timeout_hit = 1'b1;
               state_d     = StIdle;
            end else begin
               to_dec = 1'b1;
            end
         end
         StGap: begin
            if (gap_zero) begin
               state_d = StIdle;
            end else begin
               gap_dec = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         pop_q     <= 1'b0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         tx_data_q <= '0;
         sent_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         // Strobes are registered against the next state so they line up with it.
         pop_q   <= (state_d == StLoad);
         start_q <= (state_d == StStart);
         busy_q  <= (state_d != StIdle);
         if (state_q == StLoad) begin
            tx_data_q <= bus.fifo_rdata;
         end
         if (done_hit) begin
            sent_q <= sent_q + CNT_W'(1);
         end
         if (timeout_hit) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

   assign bus.fifo_pop = pop_q;
   assign bus.tx_start = start_q;
   assign bus.tx_data  = tx_data_q;
   assign busy         = busy_q;
   assign sent_cnt     = sent_q;
   assign err          = err_q;

endmodule

// File: tb/tb_fifo_tx_sched.sv
// Bench for fifo_tx_sched: two instances (gap 0 and gap 3) share stimulus; a timestamp
// model predicts every output each cycle, plus directed literal checks per scenario.
module tb_fifo_tx_sched;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 16;
   localparam int unsigned TO = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable = 1'b0;
   logic          err_clr = 1'b0;
   logic          push_req = 1'b0;
   logic [DW-1:0] push_data = '0;
   logic          tx_hang = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic          busy_w [2];
   logic [CW-1:0] sent_w [2];
   logic          err_w [2];
   int            fifo_cnt [2];
   int            n_start [2] = '{0, 0};
   int            last_start [2] = '{0, 0};
   int            last_gap [2] = '{0, 0};
   int            err_rise [2] = '{0, 0};
   logic [DW-1:0] slog [2][4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int unsigned Gap = (g == 0) ? 0 : 3;

      fifo_tx_sched_if #(.DATA_W(DW)) bus ();

      fifo_tx_sched #(
         .DATA_W         (DW),
         .GAP_CYCLES     (Gap),
         .TIMEOUT_CYCLES (TO),
         .CNT_W          (CW)
      ) dut (
         .clk      (clk),
         .rst      (rst),
         .enable   (enable),
         .err_clr  (err_clr),
         .bus      (bus),
         .busy     (busy_w[g]),
         .sent_cnt (sent_w[g]),
         .err      (err_w[g])
      );

      // 4-deep FIFO environment with combinational read port
      logic [DW-1:0] mem [4] = '{default: '0};
      int wp = 0;
      int rp = 0;
      int cnt = 0;
      always @(posedge clk) begin
         if (bus.fifo_pop && cnt > 0) rp <= (rp + 1) % 4;
         if (push_req && cnt < 4) begin
            mem[wp] <= push_data;
            wp <= (wp + 1) % 4;
         end
         cnt <= cnt + ((push_req && cnt < 4) ? 1 : 0) - ((bus.fifo_pop && cnt > 0) ? 1 : 0);
      end
      assign bus.fifo_empty = (cnt == 0);
      assign bus.fifo_rdata = mem[rp];
      assign fifo_cnt[g] = cnt;

      // Transmitter: busy for 10 cycles, tx_done in the 10th cycle after tx_start
      int   tcnt;
      logic tbusy, tdone;
      always @(posedge clk or negedge rst) begin
         if (!rst) begin
            tcnt <= 0; tbusy <= 1'b0; tdone <= 1'b0;
         end else if (bus.tx_start && !tx_hang) begin
            tcnt <= 10; tbusy <= 1'b1; tdone <= 1'b0;
         end else if (tcnt > 0) begin
            tcnt <= tcnt - 1; tbusy <= (tcnt > 1); tdone <= (tcnt == 2);
         end else begin
            tdone <= 1'b0;
         end
      end
      assign bus.tx_busy = tbusy;
      assign bus.tx_done = tdone;

      // Model: a launch decided in cycle c pops in c+1, starts in c+2, waits from c+3.
      bit            m_act = 0;
      bit            m_wait = 0;
      int            t_load = -10;
      int            rel_at = -10;
      int            m_sent = 0;
      bit            m_err = 0;
      logic [DW-1:0] m_data = '0;
      logic [DW-1:0] q [$];
      int            mc;
      bit            mtout;
      always @(posedge clk or negedge rst) begin
         if (!rst) begin
            m_act = 0; m_wait = 0; m_sent = 0; m_err = 0; m_data = '0;
         end else begin
            mc = cyc;
            mtout = 0;
            if (!m_act) begin
               if (enable && q.size() > 0 && !bus.tx_busy) begin
                  m_act = 1; m_wait = 1; t_load = mc + 1;
               end
            end else if (m_wait) begin
               if (mc == t_load) begin
                  m_data = q.pop_front();
               end else if (mc >= t_load + 2) begin
                  if (bus.tx_done) begin
                     m_sent++;
                     m_wait = 0;
                     if (Gap == 0) m_act = 0;
                     else rel_at = mc + 1 + Gap;
                  end else if (mc == t_load + 1 + TO) begin
                     mtout = 1; m_act = 0; m_wait = 0;
                  end
               end
            end else if (mc + 1 == rel_at) begin
               m_act = 0;
            end
            if (push_req && q.size() < 4) q.push_back(push_data);
            if (mtout) m_err = 1;
            else if (err_clr) m_err = 0;
         end
      end

      always @(negedge clk) begin
         if (rst) begin
            check($sformatf("i%0d pop", g), bus.fifo_pop, m_act && (cyc == t_load));
            check($sformatf("i%0d start", g), bus.tx_start, m_act && (cyc == t_load + 1));
            check($sformatf("i%0d busy", g), busy_w[g], m_act);
            check($sformatf("i%0d sent", g), sent_w[g], 32'(m_sent));
            check($sformatf("i%0d err", g), err_w[g], m_err);
            check($sformatf("i%0d data", g), bus.tx_data, m_data);
            check($sformatf("i%0d pop_empty", g), bus.fifo_pop && bus.fifo_empty, 0);
         end
      end

      // Observation log for the directed checks
      int   last_done = 0;
      logic eprev = 1'b0;
      always @(posedge clk) begin
         eprev <= err_w[g];
         if (bus.tx_done) last_done <= cyc;
         if (bus.fifo_pop) last_gap[g] <= cyc - last_done;
         if (bus.tx_start) begin
            slog[g][n_start[g] % 4] <= bus.tx_data;
            n_start[g] <= n_start[g] + 1;
            last_start[g] <= cyc;
         end
         if (err_w[g] && !eprev) err_rise[g] <= cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [DW-1:0] b);
      push_req = 1'b1;
      push_data = b;
      @(negedge clk);
      push_req = 1'b0;
   endtask

   task automatic wait_start(input int prev, input int maxc);
      int k = 0;
      while (n_start[0] == prev && k < maxc) begin
         @(negedge clk);
         k++;
      end
      check("start seen", n_start[0] != prev, 1);
   endtask

   initial begin
      logic [DW-1:0] exp4 [4];
      int n0;
      exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};

      tick(2);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst busy%0d", i), busy_w[i], 0);
         check($sformatf("rst sent%0d", i), sent_w[i], 0);
         check($sformatf("rst err%0d", i), err_w[i], 0);
      end
      check("rst data0", g_inst[0].bus.tx_data, 0);
      check("rst pop1", g_inst[1].bus.fifo_pop, 0);
      rst = 1'b1;
      tick(1);

      // single byte
      n0 = n_start[0];
      push(8'hA5);
      enable = 1'b1;
      wait_start(n0, 20);
      tick(15);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("t1 data%0d", i), slog[i][n0 % 4], 8'hA5);
         check($sformatf("t1 sent%0d", i), sent_w[i], 1);
         check($sformatf("t1 empty%0d", i), fifo_cnt[i], 0);
         check($sformatf("t1 busy%0d", i), busy_w[i], 0);
      end
      check("t1 hold", g_inst[0].bus.tx_data, 8'hA5);

      // four bytes back to back, order preserved
      n0 = n_start[0];
      for (int k = 0; k < 4; k++) push(exp4[k]);
      tick(80);
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 4; k++) begin
            check($sformatf("t2 byte%0d.%0d", i, k), slog[i][(n0 + k) % 4], exp4[k]);
         end
         check($sformatf("t2 sent%0d", i), sent_w[i], 5);
      end

      // done-to-next-pop distance: 1 idle + gap cycles + 1
      enable = 1'b0;
      push(8'h55);
      push(8'h66);
      enable = 1'b1;
      tick(45);
      check("t3 gap0", last_gap[0], 2);
      check("t3 gap3", last_gap[1], 5);
      check("t3 sent1", sent_w[1], 7);

      // enable dropped while waiting for tx_done
      enable = 1'b0;
      push(8'h77);
      push(8'h88);
      n0 = n_start[0];
      enable = 1'b1;
      wait_start(n0, 20);
      tick(3);
      enable = 1'b0;
      tick(30);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("t4 sent%0d", i), sent_w[i], 8);
         check($sformatf("t4 left%0d", i), fifo_cnt[i], 1);
         check($sformatf("t4 busy%0d", i), busy_w[i], 0);
      end
      enable = 1'b1;
      tick(25);
      check("t4 resent0", sent_w[0], 9);
      check("t4 resent1", sent_w[1], 9);

      // watchdog: err rises in the cycle after the 20th wait cycle
      tx_hang = 1'b1;
      n0 = n_start[0];
      push(8'h99);
      wait_start(n0, 20);
      tick(30);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("t5 err%0d", i), err_w[i], 1);
         check($sformatf("t5 sent%0d", i), sent_w[i], 9);
         check($sformatf("t5 busy%0d", i), busy_w[i], 0);
         check($sformatf("t5 lat%0d", i), err_rise[i] - last_start[i], 21);
      end
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("t5 clr0", err_w[0], 0);
      check("t5 clr1", err_w[1], 0);

      // timeout while err_clr is held: set still wins for one cycle
      n0 = n_start[0];
      err_clr = 1'b1;
      push(8'h9A);
      wait_start(n0, 20);
      tick(30);
      check("t5 setwins", err_rise[0] - last_start[0], 21);
      check("t5 held0", err_w[0], 0);
      err_clr = 1'b0;
      tx_hang = 1'b0;

      // asynchronous reset during WAIT_TX
      n0 = n_start[0];
      push(8'hAB);
      wait_start(n0, 20);
      tick(3);
      #2 rst = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("t6 busy%0d", i), busy_w[i], 0);
         check($sformatf("t6 sent%0d", i), sent_w[i], 0);
         check($sformatf("t6 err%0d", i), err_w[i], 0);
      end
      check("t6 data0", g_inst[0].bus.tx_data, 0);
      check("t6 data1", g_inst[1].bus.tx_data, 0);
      check("t6 start0", g_inst[0].bus.tx_start, 0);
      @(negedge clk);
      rst = 1'b1;
      tick(1);
      check("t6 lost", fifo_cnt[0], 0);
      n0 = n_start[0];
      push(8'hCD);
      wait_start(n0, 20);
      tick(20);
      check("t6 after0", sent_w[0], 1);
      check("t6 after1", sent_w[1], 1);
      check("t6 adata", slog[1][n0 % 4], 8'hCD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
